alu_issue_queue: RTL and testbench
==================================

// Module: alu_issue_queue
// PURPOSE
//   Operand-collecting issue buffer that feeds the execute-stage alu. Holds up to DEPTH
//   dispatched ALU ops, captures missing source operands from the common data bus (CDB),
//   and issues the oldest op with both operands ready as {ctrl_bits, sourceA, sourceB, dest tag}.
//   Sits between rename/dispatch and the alu. The alu's result and branch outcome return on the CDB.
// PARAMETERS
//   DEPTH   4    number of entries (>=2)
//   XLEN    64   operand width (MemoryWord)
//   TAG_W   6    physical-register / ROB tag width
//   CTRL_W  16   width of packed control_bits (usign, aluop, ...)
// PORTS
//   clk            in   1       clock, rising edge
//   reset          in   1       asynchronous, active-high
//   flush          in   1       synchronous squash of all entries
//   disp_valid     in   1       dispatch request
//   disp_ready     out  1       entry free; dispatch accepted when valid&&ready
//   disp_ctrl      in   CTRL_W  control_bits of the op
//   disp_a_rdy     in   1       operand A value valid
//   disp_a_tag     in   TAG_W   producer tag of A when not ready
//   disp_a_val     in   XLEN    value of A when ready
//   disp_b_rdy/disp_b_tag/disp_b_val    same for operand B
//   disp_dst_tag   in   TAG_W   destination tag
//   cdb_valid      in   1       CDB broadcast valid (one per cycle)
//   cdb_tag        in   TAG_W   broadcast tag
//   cdb_val        in   XLEN    broadcast value
//   iss_valid      out  1       an entry has both operands ready
//   iss_ready      in   1       alu stage accepts
//   iss_ctrl       out  CTRL_W  to alu ctrl_bits
//   iss_srcA       out  XLEN    to alu sourceA
//   iss_srcB       out  XLEN    to alu sourceB
//   iss_dst_tag    out  TAG_W   tag of issued op
//   occupancy      out  $clog2(DEPTH+1)  valid entries
// BEHAVIOUR
//   - Reset: all entries invalid. occupancy=0, disp_ready=1, iss_valid=0, iss_* payload=0.
//   - Storage is a compacting queue. Index 0 is oldest. New entries go to index occupancy.
//     On issue of entry k, entries k+1..occ-1 shift down by one in the same cycle.
//   - disp_ready = (occupancy < DEPTH), from registered state only.
//     Full: no accept, even in a cycle that also issues (no pass-through).
//   - Wake-up: each valid entry with an operand not ready and tag==cdb_tag while cdb_valid
//     captures cdb_val and sets that operand ready at the clock edge.
//     A and B may wake together if their tags are equal.
//   - Dispatch bypass: an incoming operand with rdy=0 whose tag matches the same-cycle CDB
//     is written as ready with cdb_val. No wake-up is lost.
//   - Select: iss_valid = any valid entry with both operands ready.
//     Payload comes from the lowest such index (oldest ready).
//     Selection and payload are combinational from registered entry state.
//   - Issue handshake: entry is removed when iss_valid && iss_ready.
//     If iss_ready=0, the same oldest-ready entry is presented again next cycle.
//     An older entry that becomes ready takes priority over a previously presented younger one.
//   - Latency: dispatch with both operands ready in cycle N -> iss_valid in N+1.
//     CDB wake (or bypass) in cycle N -> issuable in N+1. There is no same-cycle CDB-to-issue path.
//   - Simultaneous dispatch and issue: the shift is applied first, then the new entry goes
//     to index (occupancy-1). Occupancy is unchanged.
//     CDB wake-up applies to shifted entries using their post-shift positions.
//   - Flush: all entries invalid at the next edge. Dispatch, wake-up and issue in that cycle
//     have no effect on state; occupancy=0 next cycle.
//     iss_valid may be asserted during the flush cycle; the alu stage is flushed by the same signal.
//   - Async reset mid-operation: immediate return to the reset state. In-flight contents are discarded.
//   - Payload is passed through unmodified. The queue interprets no aluop or usign bits.
// TESTING
//   1. Reset, then dispatch op (A=5, B=7, both ready, dst=3) with iss_ready=1
//      -> next cycle iss_valid=1, srcA=5, srcB=7, dst_tag=3; after issue, occupancy=0.
//   2. Dispatch A tag=9 not ready, B=1 ready; two cycles later cdb(tag=9, val=0x10)
//      -> iss_valid rises the cycle after the CDB with srcA=0x10.
//   3. Dispatch with A tag=4 not ready while cdb(tag=4, val=0xFF) in the same cycle
//      -> bypass captured; iss_valid next cycle with srcA=0xFF.
//   4. Fill 4 entries with all ready and iss_ready=0 -> disp_ready=0, occupancy=4.
//      Then iss_ready=1 -> issue in dispatch order dst 0,1,2,3 on consecutive cycles.
//   5. Entry0 waiting on tag 7, entry1 ready -> entry1 issues first.
//      cdb tag 7 -> entry0 issues next; occupancy decrements correctly through the shift.
//   6. Three entries valid, assert flush concurrently with disp_valid and cdb_valid
//      -> occupancy=0 and iss_valid=0 next cycle, dispatched op dropped.
//      Repeat with an async reset pulse mid-cycle -> same outcome, immediate.

Source files
------------

// File: rtl/alu_issue_queue_if.sv
// Dispatch / CDB / issue bundle between rename, the issue queue and the alu.
interface alu_issue_queue_if #(
    parameter int DEPTH  = 4,
    parameter int XLEN   = 64,
    parameter int TAG_W  = 6,
    parameter int CTRL_W = 16
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              flush;
    logic              disp_valid;
    logic              disp_ready;
    logic [CTRL_W-1:0] disp_ctrl;
    logic              disp_a_rdy;
    logic [TAG_W-1:0]  disp_a_tag;
    logic [XLEN-1:0]   disp_a_val;
    logic              disp_b_rdy;
    logic [TAG_W-1:0]  disp_b_tag;
    logic [XLEN-1:0]   disp_b_val;
    logic [TAG_W-1:0]  disp_dst_tag;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [XLEN-1:0]   cdb_val;
    logic              iss_valid;
    logic              iss_ready;
    logic [CTRL_W-1:0] iss_ctrl;
    logic [XLEN-1:0]   iss_srcA;
    logic [XLEN-1:0]   iss_srcB;
    logic [TAG_W-1:0]  iss_dst_tag;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output flush, disp_valid, disp_ctrl, disp_a_rdy, disp_a_tag, disp_a_val,
               disp_b_rdy, disp_b_tag, disp_b_val, disp_dst_tag,
               cdb_valid, cdb_tag, cdb_val, iss_ready,
        input  disp_ready, iss_valid, iss_ctrl, iss_srcA, iss_srcB, iss_dst_tag, occupancy
    );

    modport slave (
        input  flush, disp_valid, disp_ctrl, disp_a_rdy, disp_a_tag, disp_a_val,
               disp_b_rdy, disp_b_tag, disp_b_val, disp_dst_tag,
               cdb_valid, cdb_tag, cdb_val, iss_ready,
        output disp_ready, iss_valid, iss_ctrl, iss_srcA, iss_srcB, iss_dst_tag, occupancy
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Operand-collecting issue buffer in front of the alu. Compacting queue,
// index 0 oldest; issues the oldest entry whose operands are both present.
module alu_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int XLEN   = 64,
    parameter int TAG_W  = 6,
    parameter int CTRL_W = 16
) (
    input logic          clk,
    input logic          reset,
    alu_issue_queue_if.slave bus
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic              vld;
        logic [CTRL_W-1:0] ctrl;
        logic              a_rdy;
        logic [TAG_W-1:0]  a_tag;
        logic [XLEN-1:0]   a_val;
        logic              b_rdy;
        logic [TAG_W-1:0]  b_tag;
        logic [XLEN-1:0]   b_val;
        logic [TAG_W-1:0]  dst;
    } entry_t;

    entry_t            q   [DEPTH];
    entry_t            nxt [DEPTH];
    entry_t            ext [DEPTH+1];
    entry_t            new_e;
    logic [OCC_W-1:0]  occ, occ_nxt, wr_idx;
    logic [DEPTH-1:0]  rdy_vec;
    logic [IDX_W-1:0]  sel;
    logic              do_iss, do_disp;

    // CDB capture for one entry; the same rule serves wake-up and dispatch bypass.
    function automatic entry_t wake(input entry_t e, input logic cv,
                                    input logic [TAG_W-1:0] ct, input logic [XLEN-1:0] cval);
        entry_t r;
        r = e;
        if (r.vld && cv) begin
            if (!r.a_rdy && r.a_tag == ct) begin
                r.a_rdy = 1'b1;
                r.a_val = cval;
            end
            if (!r.b_rdy && r.b_tag == ct) begin
                r.b_rdy = 1'b1;
                r.b_val = cval;
            end
        end
        return r;
    endfunction

    // Oldest-ready select from registered state only (no CDB-to-issue path).
    always_comb begin
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy_vec[i] = q[i].vld & q[i].a_rdy & q[i].b_rdy;
            if (rdy_vec[i]) sel = IDX_W'(i);
        end
    end

    assign bus.iss_valid   = |rdy_vec;
    assign bus.iss_ctrl    = bus.iss_valid ? q[sel].ctrl  : '0;
    assign bus.iss_srcA    = bus.iss_valid ? q[sel].a_val : '0;
    assign bus.iss_srcB    = bus.iss_valid ? q[sel].b_val : '0;
    assign bus.iss_dst_tag = bus.iss_valid ? q[sel].dst   : '0;
    assign bus.disp_ready  = (occ < OCC_W'(DEPTH));
    assign bus.occupancy   = occ;

    // Next state: compact out the issued entry, wake the survivors, append the new op.
    always_comb begin
        do_iss  = bus.iss_valid & bus.iss_ready;
        do_disp = bus.disp_valid & bus.disp_ready;

        for (int i = 0; i < DEPTH; i++) ext[i] = q[i];
        ext[DEPTH] = '0;

        new_e       = '0;
        new_e.vld   = 1'b1;
        new_e.ctrl  = bus.disp_ctrl;
        new_e.a_rdy = bus.disp_a_rdy;
        new_e.a_tag = bus.disp_a_tag;
        new_e.a_val = bus.disp_a_val;
        new_e.b_rdy = bus.disp_b_rdy;
        new_e.b_tag = bus.disp_b_tag;
        new_e.b_val = bus.disp_b_val;
        new_e.dst   = bus.disp_dst_tag;
        new_e       = wake(new_e, bus.cdb_valid, bus.cdb_tag, bus.cdb_val);

        // With an issue in the same cycle the tail has moved down one slot.
        wr_idx = do_iss ? occ - OCC_W'(1) : occ;

        for (int i = 0; i < DEPTH; i++) begin
            nxt[i] = (do_iss && i >= int'(sel)) ? ext[i+1] : q[i];
            nxt[i] = wake(nxt[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_val);
            if (do_disp && int'(wr_idx) == i) nxt[i] = new_e;
        end

        occ_nxt = occ;
        if (do_disp && !do_iss)      occ_nxt = occ + OCC_W'(1);
        else if (!do_disp && do_iss) occ_nxt = occ - OCC_W'(1);

        // Squash overrides everything that happened this cycle.
        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) nxt[i] = '0;
            occ_nxt = '0;
        end
    end

    // Entry storage and occupancy; reset discards all in-flight contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            occ <= occ_nxt;
            for (int i = 0; i < DEPTH; i++) q[i] <= nxt[i];
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: queue-based reference model predicts
// issues, a separate monitor compares whatever the DUT actually issues.
module tb_alu_issue_queue;
    localparam int DEPTH  = 4;
    localparam int XLEN   = 64;
    localparam int TAG_W  = 6;
    localparam int CTRL_W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_issue_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .CTRL_W(CTRL_W)) bus();
    alu_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        bit                a_rdy;
        logic [TAG_W-1:0]  a_tag;
        logic [XLEN-1:0]   a_val;
        bit                b_rdy;
        logic [TAG_W-1:0]  b_tag;
        logic [XLEN-1:0]   b_val;
        logic [TAG_W-1:0]  dst;
    } op_t;

    op_t mq[$];     // model contents, oldest first
    op_t exp_q[$];  // predicted issues for the monitor
    int  vectors = 0;
    int  miscompares = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reset empties the model at once, like the DUT.
    always @(posedge reset) begin
        mq.delete();
        exp_q.delete();
    end

    // Reference model: predict this cycle's outputs, then advance on the inputs.
    always @(negedge clk) begin
        int  k;
        bit  acc;
        bit  fire;
        op_t n;
        if (!reset) begin
            k = -1;
            for (int i = 0; i < mq.size(); i++)
                if (mq[i].a_rdy && mq[i].b_rdy) begin
                    k = i;
                    break;
                end
            chk("occupancy", XLEN'(bus.occupancy), XLEN'(mq.size()));
            chk("disp_ready", XLEN'(bus.disp_ready), XLEN'(mq.size() < DEPTH));
            chk("iss_valid", XLEN'(bus.iss_valid), XLEN'(k >= 0));
            fire = (k >= 0) && bus.iss_ready;
            if (fire) exp_q.push_back(mq[k]);
            if (bus.flush) mq.delete();
            else begin
                acc = bus.disp_valid && (mq.size() < DEPTH);
                if (fire) mq.delete(k);
                if (acc) begin
                    n.ctrl = bus.disp_ctrl;
                    n.a_rdy = bus.disp_a_rdy; n.a_tag = bus.disp_a_tag; n.a_val = bus.disp_a_val;
                    n.b_rdy = bus.disp_b_rdy; n.b_tag = bus.disp_b_tag; n.b_val = bus.disp_b_val;
                    n.dst = bus.disp_dst_tag;
                    mq.push_back(n);
                end
                if (bus.cdb_valid)
                    foreach (mq[i]) begin
                        if (!mq[i].a_rdy && mq[i].a_tag == bus.cdb_tag) begin
                            mq[i].a_rdy = 1'b1; mq[i].a_val = bus.cdb_val;
                        end
                        if (!mq[i].b_rdy && mq[i].b_tag == bus.cdb_tag) begin
                            mq[i].b_rdy = 1'b1; mq[i].b_val = bus.cdb_val;
                        end
                    end
            end
        end
    end

    // Monitor: every DUT issue must match the next predicted one.
    always @(negedge clk) begin
        op_t e;
        #1;
        if (!reset && bus.iss_valid && bus.iss_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL issue_unexpected: got dst %0h, expected no issue at %0t", bus.iss_dst_tag, $time);
            end else begin
                e = exp_q.pop_front();
                chk("iss_ctrl", XLEN'(bus.iss_ctrl), XLEN'(e.ctrl));
                chk("iss_srcA", bus.iss_srcA, e.a_val);
                chk("iss_srcB", bus.iss_srcB, e.b_val);
                chk("iss_dst_tag", XLEN'(bus.iss_dst_tag), XLEN'(e.dst));
            end
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_missing: got no issue, expected dst %0h at %0t", exp_q[0].dst, $time);
            exp_q.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected end of run");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush = 1'b0;
        bus.disp_valid = 1'b0;
        bus.cdb_valid = 1'b0;
    endtask

    task automatic disp(input bit ar, input logic [TAG_W-1:0] at, input logic [XLEN-1:0] av,
                        input bit br, input logic [TAG_W-1:0] bt, input logic [XLEN-1:0] bv,
                        input logic [TAG_W-1:0] dst);
        bus.disp_valid = 1'b1;
        bus.disp_ctrl  = CTRL_W'($urandom);
        bus.disp_a_rdy = ar; bus.disp_a_tag = at; bus.disp_a_val = av;
        bus.disp_b_rdy = br; bus.disp_b_tag = bt; bus.disp_b_val = bv;
        bus.disp_dst_tag = dst;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag = t;
        bus.cdb_val = v;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        bus.iss_ready = 1'b0;
        disp(1, 0, 0, 1, 0, 0, 0);
        bus.disp_valid = 1'b0;
        cdb(0, 0);
        bus.cdb_valid = 1'b0;
        repeat (2) step();
        chk("rst_occupancy", XLEN'(bus.occupancy), 0);
        chk("rst_disp_ready", XLEN'(bus.disp_ready), 1);
        chk("rst_iss_valid", XLEN'(bus.iss_valid), 0);
        chk("rst_iss_ctrl", XLEN'(bus.iss_ctrl), 0);
        chk("rst_iss_srcA", bus.iss_srcA, 0);
        chk("rst_iss_srcB", bus.iss_srcB, 0);
        chk("rst_iss_dst", XLEN'(bus.iss_dst_tag), 0);
        reset = 1'b0;
        step();

        // basic ready dispatch
        bus.iss_ready = 1'b1;
        disp(1, 0, 5, 1, 0, 7, 3); step();
        idle(); repeat (3) step();

        // wake-up from CDB two cycles after dispatch
        disp(0, 9, 0, 1, 0, 1, 5); step();
        idle(); step();
        cdb(9, 'h10); step();
        idle(); repeat (3) step();

        // same-cycle dispatch bypass
        disp(0, 4, 0, 1, 0, 2, 6); cdb(4, 'hFF); step();
        idle(); repeat (3) step();

        // fill to full, refuse a fifth, then drain in order
        bus.iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(1, 0, XLEN'(100 + i), 1, 0, XLEN'(200 + i), TAG_W'(i)); step();
        end
        disp(1, 0, 1, 1, 0, 1, 9); step();
        chk("full_occupancy", XLEN'(bus.occupancy), 4);
        chk("full_disp_ready", XLEN'(bus.disp_ready), 0);
        idle(); bus.iss_ready = 1'b1;
        repeat (6) step();

        // younger ready entry overtakes an older waiting one
        bus.iss_ready = 1'b0;
        disp(0, 7, 0, 1, 0, 3, 10); step();
        disp(1, 0, 11, 1, 0, 12, 11); step();
        idle(); bus.iss_ready = 1'b1;
        repeat (2) step();
        cdb(7, 'h77); step();
        idle(); repeat (3) step();

        // flush with concurrent dispatch and CDB
        bus.iss_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(0, TAG_W'(i + 1), 0, 1, 0, 1, TAG_W'(20 + i)); step();
        end
        disp(1, 0, 1, 1, 0, 2, 30); cdb(1, 'h55); bus.flush = 1'b1; step();
        idle(); repeat (2) step();

        // async reset pulse between edges
        for (int i = 0; i < 3; i++) begin
            disp(1, 0, XLEN'(i), 1, 0, XLEN'(i), TAG_W'(40 + i)); step();
        end
        disp(1, 0, 9, 1, 0, 9, 50); cdb(2, 'h66);
        #1 reset = 1'b1;
        #1;
        chk("arst_occupancy", XLEN'(bus.occupancy), 0);
        chk("arst_iss_valid", XLEN'(bus.iss_valid), 0);
        chk("arst_disp_ready", XLEN'(bus.disp_ready), 1);
        idle();
        #1 reset = 1'b0;
        repeat (2) step();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            idle();
            if ($urandom_range(0, 99) < 60)
                disp(1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 7)), {$urandom, $urandom},
                     1'($urandom_range(0, 1)), TAG_W'($urandom_range(0, 7)), {$urandom, $urandom},
                     TAG_W'($urandom));
            if ($urandom_range(0, 99) < 50)
                cdb(TAG_W'($urandom_range(0, 7)), {$urandom, $urandom});
            bus.iss_ready = ($urandom_range(0, 99) < 70);
            bus.flush = ($urandom_range(0, 99) < 2);
            step();
        end

        idle();
        bus.iss_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cdb(TAG_W'(i), {$urandom, $urandom}); step();
        end
        idle(); repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
